// File: rtl/reg_file_wr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_wr_arb_pkg                                                        |
// | Shared register-file definitions: default sizes and requester selectors.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package reg_file_wr_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_sel_e;

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_wr_arb_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_wr_arb_slot                                                       |
// | One-deep write request holding register with age bit and ready logic.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_file_wr_arb_slot
    import reg_file_wr_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_grant,
    output logic             o_ready,
    output logic             o_valid,
    output logic [AW-1:0]    o_addr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_age
);

    logic             r_valid;
    logic             r_age;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_data;

    // Ready depends only on held state and the grant, never on i_valid.
    assign o_ready = !r_valid || i_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_age   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_age   <= 1'b0;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_grant) begin
            r_valid <= 1'b0;
            r_age   <= 1'b0;
        end else if (r_valid) begin
            // Survived an edge without being written: older than any fresh load.
            r_age   <= 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_age   = r_age;

endmodule
`default_nettype wire

// File: rtl/reg_file_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_wr_arb                                                            |
// | Two-requester register-file write arbiter with destination scoreboard.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_file_wr_arb
    import reg_file_wr_arb_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int SIZE  = DEF_SIZE,
    localparam int AW    = addr_width(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             aValid,
    input  logic [AW-1:0]    aAddr,
    input  logic [WIDTH-1:0] aData,
    output logic             aReady,
    input  logic             bValid,
    input  logic [AW-1:0]    bAddr,
    input  logic [WIDTH-1:0] bData,
    output logic             bReady,
    input  logic             rsvValid,
    input  logic [AW-1:0]    rsvAddr,
    output logic             rsvReady,
    output logic             write,
    output logic [AW-1:0]    wrAddr,
    output logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddrA,
    input  logic [AW-1:0]    rdAddrB,
    output logic             busyA,
    output logic             busyB
);

    logic             w_a_valid, w_b_valid;
    logic             w_a_age,   w_b_age;
    logic [AW-1:0]    w_a_addr,  w_b_addr;
    logic [WIDTH-1:0] w_a_data,  w_b_data;
    logic             w_grant_a, w_grant_b;
    req_sel_e         r_ptr;
    logic [SIZE-1:0]  r_pend;

    reg_file_wr_arb_slot #(.WIDTH(WIDTH), .AW(AW)) u_slot_a (
        .clk     (clk),
        .rst     (rst),
        .i_valid (aValid),
        .i_addr  (aAddr),
        .i_data  (aData),
        .i_grant (w_grant_a),
        .o_ready (aReady),
        .o_valid (w_a_valid),
        .o_addr  (w_a_addr),
        .o_data  (w_a_data),
        .o_age   (w_a_age)
    );

    reg_file_wr_arb_slot #(.WIDTH(WIDTH), .AW(AW)) u_slot_b (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bValid),
        .i_addr  (bAddr),
        .i_data  (bData),
        .i_grant (w_grant_b),
        .o_ready (bReady),
        .o_valid (w_b_valid),
        .o_addr  (w_b_addr),
        .o_data  (w_b_data),
        .o_age   (w_b_age)
    );

    // Older entry wins; equal age falls back to the round-robin pointer.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_a_valid && w_b_valid) begin
            if (w_a_age != w_b_age)
                w_grant_a = w_a_age;
            else
                w_grant_a = (r_ptr == REQ_A);
            w_grant_b = !w_grant_a;
        end else begin
            w_grant_a = w_a_valid;
            w_grant_b = w_b_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ptr <= REQ_A;
        else if (w_grant_a)
            r_ptr <= REQ_B;
        else if (w_grant_b)
            r_ptr <= REQ_A;
    end

    always_comb begin
        write  = w_a_valid || w_b_valid;
        wrAddr = '0;
        wrData = '0;
        if (w_grant_a) begin
            wrAddr = w_a_addr;
            wrData = w_a_data;
        end else if (w_grant_b) begin
            wrAddr = w_b_addr;
            wrData = w_b_data;
        end
    end

    assign rsvReady = !r_pend[rsvAddr] || (write && (wrAddr == rsvAddr));
    assign busyA    =  r_pend[rdAddrA] && !(write && (wrAddr == rdAddrA));
    assign busyB    =  r_pend[rdAddrB] && !(write && (wrAddr == rdAddrB));

    // A reservation landing on the same edge as the clearing write wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (rsvValid && rsvReady && (rsvAddr == AW'(i)))
                    r_pend[i] <= 1'b1;
                else if (write && (wrAddr == AW'(i)))
                    r_pend[i] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_file_wr_arb                                                         |
// | Scoreboard bench: transaction-level model predicts writes and flags.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_file_wr_arb;

    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             aValid = 1'b0, bValid = 1'b0, rsvValid = 1'b0;
    logic [AW-1:0]    aAddr = '0, bAddr = '0, rsvAddr = '0, rdAddrA = '0, rdAddrB = '0;
    logic [WIDTH-1:0] aData = '0, bData = '0;
    logic             aReady, bReady, rsvReady, write, busyA, busyB;
    logic [AW-1:0]    wrAddr;
    logic [WIDTH-1:0] wrData;

    reg_file_wr_arb #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
        .rsvValid(rsvValid), .rsvAddr(rsvAddr), .rsvReady(rsvReady),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .busyA(busyA), .busyB(busyB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entries stamped with their load cycle; oldest stamp wins.
    bit          m_valid [2];
    logic [2:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_t     [2];
    int          m_last;
    bit          m_pend  [SIZE];
    int          cyc;
    logic [34:0] sb_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (!m_valid[0] && !m_valid[1]) return -1;
        if (!m_valid[1]) return 0;
        if (!m_valid[0]) return 1;
        if (m_t[0] < m_t[1]) return 0;
        if (m_t[1] < m_t[0]) return 1;
        return (m_last == 0) ? 1 : 0;
    endfunction

    function automatic bit m_writes_to(input logic [2:0] a);
        int g;
        g = m_grant();
        return (g >= 0) && (m_addr[g] == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < SIZE; i++) m_pend[i] = 1'b0;
        m_last = 1;
        sb_q.delete();
    endtask

    // Advance the model across one rising edge, then predict this cycle's write.
    task automatic edge_update();
        int  g;
        bit  iv [2];
        bit  rsv_ok;
        logic [2:0]  ia [2];
        logic [31:0] id [2];
        @(posedge clk);
        #1;
        g = m_grant();
        iv[0] = aValid; ia[0] = aAddr; id[0] = aData;
        iv[1] = bValid; ia[1] = bAddr; id[1] = bData;
        rsv_ok = rsvValid && (!m_pend[rsvAddr] || m_writes_to(rsvAddr));
        if (g >= 0) m_pend[m_addr[g]] = 1'b0;
        if (rsv_ok) m_pend[rsvAddr] = 1'b1;
        for (int x = 0; x < 2; x++) begin
            if (iv[x] && (!m_valid[x] || g == x)) begin
                m_valid[x] = 1'b1;
                m_addr[x]  = ia[x];
                m_data[x]  = id[x];
                m_t[x]     = cyc;
            end else if (g == x) begin
                m_valid[x] = 1'b0;
            end
        end
        if (g >= 0) m_last = g;
        cyc++;
        g = m_grant();
        if (g >= 0) sb_q.push_back({m_addr[g], m_data[g]});
    endtask

    task automatic check_comb();
        int g;
        @(negedge clk);
        g = m_grant();
        chk("aReady",   aReady,   !m_valid[0] || g == 0);
        chk("bReady",   bReady,   !m_valid[1] || g == 1);
        chk("rsvReady", rsvReady, !m_pend[rsvAddr] || m_writes_to(rsvAddr));
        chk("busyA",    busyA,    m_pend[rdAddrA] && !m_writes_to(rdAddrA));
        chk("busyB",    busyB,    m_pend[rdAddrB] && !m_writes_to(rdAddrB));
    endtask

    task automatic step(input bit av, input logic [2:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [2:0] ba, input logic [31:0] bd,
                        input bit rv, input logic [2:0] ra,
                        input logic [2:0] rda, input logic [2:0] rdb);
        edge_update();
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
        rsvValid = rv; rsvAddr = ra; rdAddrA = rda; rdAddrB = rdb;
        check_comb();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rdAddrA, rdAddrB);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_write"},  write,  1'b0);
        chk({tag, "_wrAddr"}, wrAddr, '0);
        chk({tag, "_wrData"}, wrData, '0);
        chk({tag, "_aReady"}, aReady, 1'b1);
        chk({tag, "_bReady"}, bReady, 1'b1);
        chk({tag, "_rsvRdy"}, rsvReady, 1'b1);
        chk({tag, "_busyA"},  busyA,  1'b0);
        chk({tag, "_busyB"},  busyB,  1'b0);
    endtask

    // Assert reset between edges so it acts asynchronously on held state.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        aValid = 0; bValid = 0; rsvValid = 0;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(negedge clk);
        check_reset_outputs({tag, "_hold"});
        rst = 1'b1;
    endtask

    // Monitor: every cycle with write high must match the head of the queue.
    initial begin
        logic [34:0] exp;
        forever begin
            @(negedge clk);
            if (write === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", {wrAddr, wrData}, 35'h0);
                    chk("write_when_idle", write, 1'b0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("wrAddr", wrAddr, exp[34:32]);
                    chk("wrData", wrData, exp[31:0]);
                end
            end else begin
                chk("idle_wrAddr", wrAddr, '0);
                chk("idle_wrData", wrData, '0);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("missing_write", write, 1'b1);
                end
            end
        end
    end

    initial begin
        cyc = 0;
        model_reset();
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Tie after reset (A first), with A refilled behind the older B entry.
        step(1, 3'd1, 32'hAAAA0001, 1, 3'd2, 32'hBBBB0002, 0, 0, 0, 0);
        step(1, 3'd6, 32'h66666666, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Single accept with one-cycle latency, then a tie that now favours B.
        step(1, 3'd3, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 3'd1, 32'hAAAA0001, 1, 3'd2, 32'hBBBB0002, 0, 0, 0, 0);
        idle(3);

        // Reservation of 5: busy, second reservation refused, write releases it.
        step(0, 0, 0, 0, 0, 0, 1, 3'd5, 3'd5, 3'd5);
        step(0, 0, 0, 0, 0, 0, 1, 3'd5, 3'd5, 3'd5);
        step(1, 3'd5, 32'h55555555, 0, 0, 0, 0, 3'd5, 3'd5, 3'd5);
        step(0, 0, 0, 0, 0, 0, 0, 3'd5, 3'd5, 3'd5);
        idle(2);

        // Reservation of 4 landing on the write-to-4 edge stays pending.
        step(0, 0, 0, 1, 3'd4, 32'h44444444, 0, 0, 3'd4, 3'd4);
        step(0, 0, 0, 0, 0, 0, 1, 3'd4, 3'd4, 3'd4);
        step(0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd4, 3'd4);
        idle(2);
        step(1, 3'd4, 32'h0, 0, 0, 0, 0, 0, 3'd4, 3'd4);
        idle(2);

        // Reset while both entries hold data.
        step(1, 3'd7, 32'h77777777, 1, 3'd0, 32'h00000007, 1, 3'd2, 3'd2, 3'd0);
        do_reset("midrst");
        idle(3);
        step(1, 3'd3, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset("rndrst");
            end else begin
                step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end
        idle(4);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_wr_arb.md
REG_FILE_WR_ARB -- requirements
Module: reg_file_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning register data width.
REQ-002 SHALL have parameter SIZE, default 8, meaning register count; AW = clog2(SIZE).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports aValid, aAddr, aData: input, 1/AW/WIDTH, meaning requester A write request.
REQ-006 SHALL have port aReady, output, 1, meaning requester A accept.
REQ-007 SHALL have ports bValid, bAddr, bData, bReady, same widths and meaning as requester A.
REQ-008 SHALL have ports rsvValid, rsvAddr: input, 1/AW, meaning reservation of a destination register.
REQ-009 SHALL have port rsvReady, output, 1, meaning reservation accepted.
REQ-010 SHALL have ports write, wrAddr, wrData: output, 1/AW/WIDTH, meaning the register file write port.
REQ-011 SHALL have ports rdAddrA, rdAddrB: input, AW, meaning register file read addresses.
REQ-012 SHALL have ports busyA, busyB: output, 1, meaning the addressed register has a pending write.

Function
REQ-013 SHALL hold one entry per requester (valid, addr, data); transfer occurs on an edge with xValid and xReady both high.
REQ-014 SHALL drive xReady = entry empty OR entry granted this cycle; no combinational path from xValid to xReady.
REQ-015 SHALL drive write = 1 whenever any entry is valid, with wrAddr/wrData from the granted entry; write = 0 drives wrAddr/wrData to 0.
REQ-016 SHALL grant the older entry when both are valid; on equal age (both loaded on the same edge), SHALL grant the requester not granted last (round-robin pointer).
REQ-017 SHALL update the round-robin pointer on every grant; pointer SHALL favour A after reset.
REQ-018 SHALL clear the granted entry at the edge ending its grant cycle; a new transfer into the same slot on that edge SHALL refill it.
REQ-019 SHALL yield latency of exactly 1 cycle from accept edge to write high when the other entry is empty; worst case 2 cycles.
REQ-020 SHALL keep a pending bitmask pend[0:SIZE-1]; an accepted reservation sets pend[rsvAddr]; a write clears pend[wrAddr] at the write edge.
REQ-021 SHALL, on simultaneous set and clear of the same bit, leave the bit set.
REQ-022 SHALL drive rsvReady = !pend[rsvAddr] OR (write AND wrAddr == rsvAddr).
REQ-023 SHALL drive busyA = pend[rdAddrA] AND NOT (write AND wrAddr == rdAddrA); busyB likewise.
REQ-024 SHALL accept writes to non-pending registers without error; pend is unaffected.

Reset
REQ-025 SHALL, while rst = 0, asynchronously clear both entries, pend, age, and pointer (favouring A).
REQ-026 SHALL, during and after reset, present write = 0, wrAddr = 0, wrData = 0, aReady = bReady = 1, rsvReady = 1, busyA = busyB = 0.
REQ-027 SHALL discard any held entry and reservation when reset asserts mid-operation; no write issues after reset release until a new transfer.

Structure
REQ-028 SHALL take WIDTH, SIZE, and the requester-select encoding (REQ_A = 0, REQ_B = 1) from the shared VCPU32 definitions include.
REQ-029 SHALL instantiate one sub-module, WrReqSlot, twice; each instance holds one entry together with its age bit and ready logic.
REQ-030 SHALL feed write, wrAddr, and wrData directly to the ScanRegFileUnit write port.

Verification
REQ-031 Single accept: after reset, A sends addr 3, data 0x11111111 -> write = 1 with wrAddr = 3 in the next cycle, aReady stays 1.
REQ-032 Tie: A sends addr 1, 0xAAAA0001 and B sends addr 2, 0xBBBB0002 on the same edge -> A written first, B on the following cycle; repeat -> B first.
REQ-033 Age: B accepted one edge before A, both pending -> B written before A.
REQ-034 Scoreboard: reserve addr 5 -> busyA = 1 for rdAddrA = 5; a second reservation of 5 gives rsvReady = 0; a write to 5 gives busyA = 0 in the write cycle, and rsvReady = 1.
REQ-035 Set-and-clear: a reservation of 4 lands on the same edge as a write to 4 -> pend[4] remains 1.
REQ-036 Reset mid-flight: both entries valid, rst pulsed low -> write = 0 immediately, no write after release, all readies = 1.
